// File: rtl/fp_32_to_16_round_pipe_pkg.sv
// rtl/fp_32_to_16_round_pipe_pkg.sv - shared constants, operand class enum and classifier
// Field widths, biases and the fp32 operand classifier used by the fp32->fp16 pipe.
package fp_32_to_16_round_pipe_pkg;

   localparam int FP32_EXP_W = 8;
   localparam int FP32_MAN_W = 23;
   localparam int FP16_EXP_W = 5;
   localparam int FP16_MAN_W = 10;
   localparam int FP32_BIAS  = 127;
   localparam int FP16_BIAS  = 15;
   localparam int EXP_DELTA  = FP32_BIAS - FP16_BIAS;
   localparam logic [15:0] FP16_QNAN = 16'h7E00;

   typedef enum logic [2:0] {
      CLS_ZERO,
      CLS_SUB,
      CLS_NORM,
      CLS_INF,
      CLS_NAN
   } fp_class_e;

   function automatic fp_class_e fp_classify(input logic [FP32_EXP_W-1:0] e,
                                             input logic [FP32_MAN_W-1:0] m);
      fp_class_e cls;
      if (e == '0)
         cls = (m == '0) ? CLS_ZERO : CLS_SUB;
      else if (e == '1)
         cls = (m == '0) ? CLS_INF : CLS_NAN;
      else
         cls = CLS_NORM;
      return cls;
   endfunction

endpackage

// File: rtl/fp_rne_rounder.sv
// rtl/fp_rne_rounder.sv - round-to-nearest-even on a 10-bit fp16 mantissa
// inexact_o exists only when FP_32_16_FLAGS_EN is defined.
import fp_32_to_16_round_pipe_pkg::*;

module fp_rne_rounder (
   input  logic [FP16_MAN_W-1:0] man_i,
   input  logic                  guard_i,
   input  logic                  sticky_i,
   output logic [FP16_MAN_W-1:0] man_o,
   output logic                  carry_o
`ifdef FP_32_16_FLAGS_EN
   ,
   output logic                  inexact_o
`endif
);

   logic w_round_up;

   // Ties (guard set, sticky clear) round up only when the kept lsb is odd.
   assign w_round_up = guard_i & (sticky_i | man_i[0]);
   assign {carry_o, man_o} = {1'b0, man_i} + {{FP16_MAN_W{1'b0}}, w_round_up};

`ifdef FP_32_16_FLAGS_EN
   assign inexact_o = guard_i | sticky_i;
`endif

endmodule

// File: rtl/fp_32_to_16_round_pipe.sv
// rtl/fp_32_to_16_round_pipe.sv - two-stage fp32 to fp16 RNE converter with valid/ready
// Define FP_32_16_FLAGS_EN to add flags_o = {overflow, underflow, inexact}.
import fp_32_to_16_round_pipe_pkg::*;

module fp_32_to_16_round_pipe #(
   parameter int FTZ = 0
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        valid_i,
   output logic        ready_o,
   input  logic [31:0] operand_fp32_i,
   output logic        valid_o,
   input  logic        ready_i,
   output logic [15:0] result_o
`ifdef FP_32_16_FLAGS_EN
   ,
   output logic [2:0]  flags_o
`endif
);

   logic                  r_s1_valid;
   logic                  r_s1_sign;
   fp_class_e             r_s1_cls;
   logic signed [9:0]     r_s1_e16;
   logic [FP32_MAN_W-1:0] r_s1_man;
   logic                  r_s2_valid;
   logic [15:0]           r_result;

   logic                  w_s1_load;
   logic                  w_s2_load;
   logic                  w_sub_path;
   logic                  w_ovf_exp;
   logic [5:0]            w_sh;
   logic [46:0]           w_wide;
   logic [FP16_MAN_W-1:0] w_rnd_man;
   logic                  w_rnd_carry;
   logic [5:0]            w_exp_sum;
   logic [15:0]           w_result;
`ifdef FP_32_16_FLAGS_EN
   logic                  w_rnd_inexact;
   logic [2:0]            w_flags;
   logic [2:0]            r_flags;
`endif

   assign w_s2_load = !r_s2_valid || ready_i;
   assign w_s1_load = !r_s1_valid || w_s2_load;
   assign ready_o   = w_s1_load;
   assign valid_o   = r_s2_valid;
   assign result_o  = r_result;
`ifdef FP_32_16_FLAGS_EN
   assign flags_o   = r_flags;
`endif

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_s1_valid <= 1'b0;
         r_s2_valid <= 1'b0;
      end else begin
         if (w_s1_load) r_s1_valid <= valid_i;
         if (w_s2_load) r_s2_valid <= r_s1_valid;
      end
   end

   // S1: unpack, classify, rebias into a signed fp16 exponent.
   always_ff @(posedge clk_i) begin
      if (w_s1_load && valid_i) begin
         r_s1_sign <= operand_fp32_i[31];
         r_s1_cls  <= fp_classify(operand_fp32_i[30:23], operand_fp32_i[22:0]);
         r_s1_e16  <= 10'({2'b00, operand_fp32_i[30:23]}) - 10'(EXP_DELTA);
         r_s1_man  <= operand_fp32_i[22:0];
      end
   end

   assign w_sub_path = (r_s1_e16 <= 10'sd0);
   assign w_ovf_exp  = (r_s1_e16 >= 10'sd31);

   // Shifts beyond 13 push every significand bit into sticky, so clamp there.
   always_comb begin
      w_sh = 6'd0;
      if (r_s1_e16 < -10'sd12)
         w_sh = 6'd13;
      else if (w_sub_path)
         w_sh = 6'(10'sd1 - r_s1_e16);
   end

   assign w_wide = 47'({1'b1, r_s1_man, 24'b0} >> w_sh);

   fp_rne_rounder u_rounder (
      .man_i     (w_wide[46:37]),
      .guard_i   (w_wide[36]),
      .sticky_i  (|w_wide[35:0]),
      .man_o     (w_rnd_man),
      .carry_o   (w_rnd_carry)
`ifdef FP_32_16_FLAGS_EN
      ,
      .inexact_o (w_rnd_inexact)
`endif
   );

   assign w_exp_sum = {1'b0, (w_sub_path ? 5'd0 : r_s1_e16[4:0])} + {5'd0, w_rnd_carry};

   always_comb begin
      w_result = {r_s1_sign, 15'd0};
`ifdef FP_32_16_FLAGS_EN
      w_flags  = 3'b000;
`endif
      case (r_s1_cls)
         CLS_ZERO: w_result = {r_s1_sign, 15'd0};
         CLS_SUB: begin
            w_result = {r_s1_sign, 15'd0};
`ifdef FP_32_16_FLAGS_EN
            w_flags  = 3'b011;
`endif
         end
         CLS_INF: w_result = {r_s1_sign, 5'h1F, 10'd0};
         CLS_NAN: w_result = {r_s1_sign, FP16_QNAN[14:0]};
         default: begin
            if (w_ovf_exp || w_exp_sum == 6'd31) begin
               w_result = {r_s1_sign, 5'h1F, 10'd0};
`ifdef FP_32_16_FLAGS_EN
               w_flags  = 3'b101;
`endif
            end else if (FTZ != 0 && w_sub_path && w_exp_sum == 6'd0) begin
               w_result = {r_s1_sign, 15'd0};
`ifdef FP_32_16_FLAGS_EN
               w_flags  = 3'b011;
`endif
            end else begin
               w_result = {r_s1_sign, w_exp_sum[4:0], w_rnd_man};
`ifdef FP_32_16_FLAGS_EN
               w_flags  = {1'b0, w_rnd_inexact && (w_exp_sum == 6'd0), w_rnd_inexact};
`endif
            end
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_result <= 16'h0000;
`ifdef FP_32_16_FLAGS_EN
         r_flags  <= 3'b000;
`endif
      end else if (w_s2_load && r_s1_valid) begin
         r_result <= w_result;
`ifdef FP_32_16_FLAGS_EN
         r_flags  <= w_flags;
`endif
      end
   end

endmodule

// File: tb/tb_fp_32_to_16_round_pipe.sv
// tb/tb_fp_32_to_16_round_pipe.sv - directed bench for the fp32->fp16 pipe, FTZ=0 and FTZ=1
// Flag checks are active when FP_32_16_FLAGS_EN is defined.
module tb_fp_32_to_16_round_pipe;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        valid_i;
   logic        ready_i;
   logic [31:0] operand_fp32_i;
   logic        ready_o, valid_o, ready_f, valid_f;
   logic [15:0] result_o, result_f;
`ifdef FP_32_16_FLAGS_EN
   logic [2:0]  flags_o, flags_f;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk_i = ~clk_i;

   fp_32_to_16_round_pipe #(.FTZ(0)) dut (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .valid_i        (valid_i),
      .ready_o        (ready_o),
      .operand_fp32_i (operand_fp32_i),
      .valid_o        (valid_o),
      .ready_i        (ready_i),
      .result_o       (result_o)
`ifdef FP_32_16_FLAGS_EN
      ,
      .flags_o        (flags_o)
`endif
   );

   fp_32_to_16_round_pipe #(.FTZ(1)) dut_ftz (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .valid_i        (valid_i),
      .ready_o        (ready_f),
      .operand_fp32_i (operand_fp32_i),
      .valid_o        (valid_f),
      .ready_i        (ready_i),
      .result_o       (result_f)
`ifdef FP_32_16_FLAGS_EN
      ,
      .flags_o        (flags_f)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic run_one(input logic [31:0] op, input logic [15:0] exp_r, input logic [15:0] exp_rf,
                          input logic [2:0] exp_fl, input logic [2:0] exp_flf, input string tag);
      valid_i        = 1'b1;
      operand_fp32_i = op;
      ready_i        = 1'b1;
      @(posedge clk_i); #1;
      valid_i = 1'b0;
      chk({tag, ":lat1"}, {31'd0, valid_o}, 32'd0);
      @(posedge clk_i); #1;
      chk({tag, ":valid"}, {31'd0, valid_o}, 32'd1);
      chk({tag, ":res"}, {16'd0, result_o}, {16'd0, exp_r});
      chk({tag, ":res_ftz"}, {16'd0, result_f}, {16'd0, exp_rf});
`ifdef FP_32_16_FLAGS_EN
      chk({tag, ":flags"}, {29'd0, flags_o}, {29'd0, exp_fl});
      chk({tag, ":flags_ftz"}, {29'd0, flags_f}, {29'd0, exp_flf});
`else
      if (exp_fl != exp_flf) begin end
`endif
      @(posedge clk_i); #1;
   endtask

   logic [31:0] s_op[5];
   logic [15:0] s_res[5];
   int          fed, got, seen;

   initial begin
      rst_ni         = 1'b0;
      valid_i        = 1'b0;
      ready_i        = 1'b1;
      operand_fp32_i = 32'd0;
      @(posedge clk_i); #1;
      chk("rst:valid_o", {31'd0, valid_o}, 32'd0);
      chk("rst:ready_o", {31'd0, ready_o}, 32'd1);
      chk("rst:result_o", {16'd0, result_o}, 32'd0);
`ifdef FP_32_16_FLAGS_EN
      chk("rst:flags_o", {29'd0, flags_o}, 32'd0);
`endif
      @(negedge clk_i);
      rst_ni = 1'b1;
      @(posedge clk_i); #1;

      run_one(32'h3F800000, 16'h3C00, 16'h3C00, 3'b000, 3'b000, "one");
      run_one(32'h477FE000, 16'h7BFF, 16'h7BFF, 3'b000, 3'b000, "max_norm");
      run_one(32'h477FF000, 16'h7C00, 16'h7C00, 3'b101, 3'b101, "ovf_carry");
      run_one(32'hFFC00001, 16'hFE00, 16'hFE00, 3'b000, 3'b000, "nan");
      run_one(32'h3F801000, 16'h3C00, 16'h3C00, 3'b001, 3'b001, "tie_even");
      run_one(32'h3F803000, 16'h3C02, 16'h3C02, 3'b001, 3'b001, "tie_up");
      run_one(32'h33800000, 16'h0001, 16'h0000, 3'b000, 3'b011, "min_sub");
      run_one(32'h33000000, 16'h0000, 16'h0000, 3'b011, 3'b011, "half_min_sub");
      run_one(32'h387FE000, 16'h0400, 16'h0400, 3'b001, 3'b001, "sub_to_norm");
      run_one(32'h00000001, 16'h0000, 16'h0000, 3'b011, 3'b011, "fp32_sub");
      run_one(32'h80000000, 16'h8000, 16'h8000, 3'b000, 3'b000, "neg_zero");
      run_one(32'hFF800000, 16'hFC00, 16'hFC00, 3'b000, 3'b000, "neg_inf");
      run_one(32'h7F000000, 16'h7C00, 16'h7C00, 3'b101, 3'b101, "big_ovf");
      run_one(32'hC0000000, 16'hC000, 16'hC000, 3'b000, 3'b000, "neg_two");
      run_one(32'hB3C00000, 16'h8002, 16'h8000, 3'b011, 3'b011, "neg_sub_tie");

      s_op[0] = 32'h3F800000; s_res[0] = 16'h3C00;
      s_op[1] = 32'h477FE000; s_res[1] = 16'h7BFF;
      s_op[2] = 32'h3F803000; s_res[2] = 16'h3C02;
      s_op[3] = 32'h33800000; s_res[3] = 16'h0001;
      s_op[4] = 32'hFFC00001; s_res[4] = 16'hFE00;
      fed = 0;
      got = 0;
      for (int c = 0; c < 16; c++) begin
         ready_i        = !(c >= 2 && c <= 5);
         valid_i        = (fed < 5);
         operand_fp32_i = (fed < 5) ? s_op[fed] : 32'd0;
         #1;
         if (c >= 2 && c <= 5) begin
            chk("bp:ready_o_low", {31'd0, ready_o}, 32'd0);
            chk("bp:valid_held", {31'd0, valid_o}, 32'd1);
            chk("bp:result_held", {16'd0, result_o}, {16'd0, s_res[0]});
         end
         if (valid_o && ready_i) begin
            if (got < 5) chk("bp:order", {16'd0, result_o}, {16'd0, s_res[got]});
            got++;
         end
         if (valid_i && ready_o) fed++;
         @(posedge clk_i); #1;
      end
      valid_i = 1'b0;
      ready_i = 1'b1;
      chk("bp:delivered", got, 32'd5);
      chk("bp:fed", fed, 32'd5);

      valid_i        = 1'b1;
      operand_fp32_i = 32'h3F800000;
      @(posedge clk_i); #1;
      operand_fp32_i = 32'h477FE000;
      @(posedge clk_i); #1;
      valid_i = 1'b0;
      chk("rst_mid:in_flight", {31'd0, valid_o}, 32'd1);
      #2 rst_ni = 1'b0;
      #1;
      chk("rst_mid:valid_o", {31'd0, valid_o}, 32'd0);
      chk("rst_mid:ready_o", {31'd0, ready_o}, 32'd1);
      chk("rst_mid:result_o", {16'd0, result_o}, 32'd0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      seen = 0;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk_i); #1;
         if (valid_o) seen++;
      end
      chk("rst_mid:no_stale", seen, 32'd0);
      run_one(32'h3F803000, 16'h3C02, 16'h3C02, 3'b001, 3'b001, "post_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fp_32_to_16_round_pipe.md
FP_32_TO_16_ROUND_PIPE -- requirements
Module: fp_32_to_16_round_pipe

Interface
REQ-001 Parameters SHALL be: FTZ, default 0, 1 = flush fp16-subnormal results to signed zero.
REQ-002 clk_i  input  1  single clock, all state on rising edge.
REQ-003 rst_ni  input  1  reset, asynchronous, active-low.
REQ-004 valid_i  input  1  operand_fp32_i valid.
REQ-005 ready_o  output  1  block accepts operand this cycle.
REQ-006 operand_fp32_i  input  32  IEEE-754 binary32 operand.
REQ-007 valid_o  output  1  result_o valid.
REQ-008 ready_i  input  1  consumer accepts result this cycle.
REQ-009 result_o  output  16  IEEE-754 binary16 result.
REQ-010 flags_o  output  3  {overflow, underflow, inexact}; present only with FP_32_16_FLAGS_EN.

Function
REQ-011 Transfer SHALL occur on any edge where valid and ready are both high, on either side.
REQ-012 Datapath SHALL be two register stages: S1 unpack/classify/rebias, S2 shift/round/pack.
REQ-013 Latency SHALL be exactly 2 cycles from input transfer to valid_o with ready_i held high; throughput 1 per cycle.
REQ-014 S2 SHALL load when empty or ready_i high; S1 SHALL load when empty or S2 loads; ready_o = S1 empty or S1 advancing (no combinational path from valid_i to ready_o).
REQ-015 result_o and valid_o SHALL be held stable while valid_o high and ready_i low.
REQ-016 Results SHALL emerge in input order; no drop or duplication under any ready_i pattern.
REQ-017 Rounding SHALL be round-to-nearest, ties-to-even, using guard and sticky over all discarded bits.
REQ-018 Rebias: e16 = e32 - 112; normal path when 1 <= e16 <= 30.
REQ-019 e16 >= 31, or rounding carry raising exponent to 31, SHALL yield signed infinity, overflow=1, inexact=1.
REQ-020 e16 <= 0: hidden-one mantissa shifted right by 1-e16 then rounded; shift > 12 yields signed zero; rounding carry into bit 10 SHALL yield minimum normal 0x0400/0x8400.
REQ-021 Mantissa rounding carry 0x3FF->0x400 SHALL increment exponent.
REQ-022 fp32 zero and fp32 subnormal inputs SHALL yield signed zero (subnormal: inexact=1, underflow=1).
REQ-023 fp32 infinity SHALL yield signed infinity, no flags.
REQ-024 NaN SHALL yield {sign, 5'h1F, 10'h200}, no flags.
REQ-025 underflow SHALL be set when result is subnormal or zero-from-nonzero and inexact.
REQ-026 FTZ=1: any subnormal result SHALL become signed zero with underflow=1, inexact=1.

Reset
REQ-027 Reset SHALL asynchronously clear both stage valid bits; valid_o=0, ready_o=1, result_o=16'h0000, flags_o=3'b000.
REQ-028 Reset mid-operation SHALL discard all in-flight operands; first post-reset output comes only from new transfers.
REQ-029 Data registers MAY be left un-reset except result_o/flags_o output registers.

Configuration
REQ-030 Macro FP_32_16_FLAGS_EN defined: flags_o port and flag pipeline registers present, flags aligned with result_o.
REQ-031 Macro undefined: no flags_o port, no flag logic; result_o identical in both builds.

Structure
REQ-032 Shared package SHALL hold fp32/fp16 field-width constants, biases (127, 15), exponent delta 112, canonical NaN 16'h7E00, and the class enum {ZERO, SUB, NORM, INF, NAN}.
REQ-033 One sub-module fp_rne_rounder (mantissa + guard + sticky -> rounded mantissa, carry, inexact) SHALL be instantiated in S2; the rest stays in the top module.

Verification
REQ-034 0x3F800000 transferred at cycle 0, ready_i=1 -> result_o=0x3C00, valid_o at cycle 2, flags 000.
REQ-035 0x477FE000 -> 0x7BFF flags 000; 0x477FF000 -> 0x7C00 flags 101; 0xFFC00001 -> 0xFE00 flags 000.
REQ-036 0x3F801000 -> 0x3C00 (tie to even), 0x3F803000 -> 0x3C02, both inexact; 0x33800000 -> 0x0001; 0x33000000 -> 0x0000 flags 011; 0x387FE000 -> 0x0400.
REQ-037 Stream 5 operands, ready_i low cycles 2-5 -> ready_o low after 2 buffered, valid_o/result_o stable, all 5 results delivered in order.
REQ-038 rst_ni pulsed low with 2 operands in flight -> valid_o 0 immediately, no stale result after release; next operand returns in 2 cycles.
REQ-039 FTZ=1: 0x33800000 -> 0x0000 flags 011; build without FP_32_16_FLAGS_EN -> identical result_o sequence.
